gaussian_conv_3x3: RTL and testbench

GAUSSIAN_CONV_3X3 -- requirements
Module: gaussian_conv_3x3

---
 rtl/gaussian_conv_3x3_pkg.sv | 30 +++
 rtl/gaussian_conv_3x3_row_sum.sv | 38 +++
 rtl/gaussian_conv_3x3.sv | 193 +++++++++++++++++++
 tb/tb_gaussian_conv_3x3.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_conv_3x3_pkg.sv
// -----------------------------------------------------------------------------
// gaussian_conv_3x3_pkg
// Shared constants for the 3x3 Gaussian filter: separable kernel taps,
// normalisation shift and rounding bias, plus helpers that derive the
// intermediate datapath widths from the pixel width.
// -----------------------------------------------------------------------------
package gaussian_conv_3x3_pkg;

  // Kernel [1 2 1; 2 4 2; 1 2 1] is the outer product of [1 2 1] with itself.
  localparam int KW_CORNER = 1;
  localparam int KW_EDGE   = 2;
  localparam int KW_CENTER = 4;

  // Kernel weights sum to 16: divide by shifting, round half-up first.
  localparam int NORM_SHIFT = 4;
  localparam int ROUND_BIAS = 8;

  // Bit growth: one row sum peaks at 4*max, the full total at 16*max.
  localparam int ROW_SUM_GROWTH = 2;
  localparam int TOTAL_GROWTH   = 4;

  function automatic int row_sum_width(input int data_width);
    return data_width + ROW_SUM_GROWTH;
  endfunction

  function automatic int total_width(input int data_width);
    return data_width + TOTAL_GROWTH;
  endfunction

endpackage

// File: rtl/gaussian_conv_3x3_row_sum.sv
// -----------------------------------------------------------------------------
// gauss_row_sum
// One registered horizontal tap of the Gaussian kernel: sum = a + 2*b + c.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   load        capture a new sum this cycle (window accepted)
//   a, b, c     left, centre and right pixel of one window row
//   sum         registered row sum, DATA_WIDTH+2 bits (cannot overflow)
// -----------------------------------------------------------------------------
module gauss_row_sum
  import gaussian_conv_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 load,
  input  logic [DATA_WIDTH-1:0]                a,
  input  logic [DATA_WIDTH-1:0]                b,
  input  logic [DATA_WIDTH-1:0]                c,
  output logic [row_sum_width(DATA_WIDTH)-1:0] sum
);

  localparam int RW = row_sum_width(DATA_WIDTH);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order of always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (load) begin
      sum <= RW'(KW_CORNER) * RW'(a)
           + RW'(KW_EDGE)   * RW'(b)
           + RW'(KW_CORNER) * RW'(c);
    end
  end

endmodule

// File: rtl/gaussian_conv_3x3.sv
// -----------------------------------------------------------------------------
// gaussian_conv_3x3
// Three-stage pipelined 3x3 Gaussian blur over a streamed window.
// Stage 1: three row sums, window position flags and centre pixel.
// Stage 2: vertical combine total = r1 + 2*r2 + r3.
// Stage 3: round, normalise, saturate; border windows pass p22 through.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   en_fun                     function enable, low flushes pipeline and position
//   matrix_clken               window valid this cycle
//   data_valid                 high marks a row-wrap junk window (rejected)
//   matrix_p11..matrix_p33     3x3 window, row 1 oldest, p22 centre
//   post_clken                 post_img valid (3 cycles after acceptance)
//   post_img                   filtered or passthrough pixel, holds between outputs
//   post_border                post_img is a border passthrough
//   frame_done                 pulses with the last pixel of a frame
// -----------------------------------------------------------------------------
module gaussian_conv_3x3
  import gaussian_conv_3x3_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_fun,
  input  logic                  matrix_clken,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] matrix_p11,
  input  logic [DATA_WIDTH-1:0] matrix_p12,
  input  logic [DATA_WIDTH-1:0] matrix_p13,
  input  logic [DATA_WIDTH-1:0] matrix_p21,
  input  logic [DATA_WIDTH-1:0] matrix_p22,
  input  logic [DATA_WIDTH-1:0] matrix_p23,
  input  logic [DATA_WIDTH-1:0] matrix_p31,
  input  logic [DATA_WIDTH-1:0] matrix_p32,
  input  logic [DATA_WIDTH-1:0] matrix_p33,
  output logic                  post_clken,
  output logic [DATA_WIDTH-1:0] post_img,
  output logic                  post_border,
  output logic                  frame_done
);

  localparam int RW  = row_sum_width(DATA_WIDTH);
  localparam int TW  = total_width(DATA_WIDTH);
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RNW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0]  LAST_COL = CW'(WIDTH - 1);
  localparam logic [RNW-1:0] LAST_ROW = RNW'(DEPTH - 1);

  // Middle window row carries weights 2,4,2 = row kernel scaled by this factor.
  localparam int MID_ROW_GAIN = KW_CENTER / KW_EDGE;

  logic accept;
  assign accept = en_fun & matrix_clken & ~data_valid;

  // ---------------------------------------------------------------------------
  // Window position tracking (advances on accepted windows only)
  // ---------------------------------------------------------------------------
  logic [CW-1:0]  col, col_nxt;
  logic [RNW-1:0] row, row_nxt;
  logic           win_border, win_last;

  // NOTE: every always_comb output gets a default first, so no path through the
  // block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (accept) begin
      if (col == LAST_COL) begin
        col_nxt = '0;
        row_nxt = (row == LAST_ROW) ? '0 : row + RNW'(1);
      end else begin
        col_nxt = col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (!en_fun) begin
      // Holding en_fun low parks the position at the start of a new frame.
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  assign win_border = (col == '0) || (col == LAST_COL) ||
                      (row == '0) || (row == LAST_ROW);
  assign win_last   = (col == LAST_COL) && (row == LAST_ROW);

  // ---------------------------------------------------------------------------
  // Stage 1: row sums and side-band
  // ---------------------------------------------------------------------------
  logic [RW-1:0]         s1_r1, s1_r2, s1_r3;
  logic                  s1_valid, s1_border, s1_last;
  logic [DATA_WIDTH-1:0] s1_p22;

  gauss_row_sum #(.DATA_WIDTH(DATA_WIDTH)) u_row1 (
    .clk(clk), .rst_n(rst_n), .load(accept),
    .a(matrix_p11), .b(matrix_p12), .c(matrix_p13), .sum(s1_r1)
  );

  gauss_row_sum #(.DATA_WIDTH(DATA_WIDTH)) u_row2 (
    .clk(clk), .rst_n(rst_n), .load(accept),
    .a(matrix_p21), .b(matrix_p22), .c(matrix_p23), .sum(s1_r2)
  );

  gauss_row_sum #(.DATA_WIDTH(DATA_WIDTH)) u_row3 (
    .clk(clk), .rst_n(rst_n), .load(accept),
    .a(matrix_p31), .b(matrix_p32), .c(matrix_p33), .sum(s1_r3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_p22    <= '0;
      s1_border <= 1'b0;
      s1_last   <= 1'b0;
    end else begin
      s1_valid <= accept;  // accept already folds in en_fun
      if (accept) begin
        s1_p22    <= matrix_p22;
        s1_border <= win_border;
        s1_last   <= win_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: vertical combine
  // ---------------------------------------------------------------------------
  logic [TW-1:0]         s2_total;
  logic                  s2_valid, s2_border, s2_last;
  logic [DATA_WIDTH-1:0] s2_p22;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_total  <= '0;
      s2_p22    <= '0;
      s2_border <= 1'b0;
      s2_last   <= 1'b0;
    end else begin
      s2_valid <= s1_valid & en_fun;
      if (s1_valid) begin
        s2_total  <= TW'(s1_r1) + TW'(MID_ROW_GAIN) * TW'(s1_r2) + TW'(s1_r3);
        s2_p22    <= s1_p22;
        s2_border <= s1_border;
        s2_last   <= s1_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: round, normalise, saturate, select passthrough
  // ---------------------------------------------------------------------------
  logic [TW:0]           rnd_sum;
  logic [DATA_WIDTH:0]   rnd_q;
  logic [DATA_WIDTH-1:0] filt_pix;

  // One guard bit above the pixel range catches any result past all-ones.
  assign rnd_sum  = (TW+1)'(s2_total) + (TW+1)'(ROUND_BIAS);
  assign rnd_q    = (DATA_WIDTH+1)'(rnd_sum >> NORM_SHIFT);
  assign filt_pix = rnd_q[DATA_WIDTH] ? '1 : rnd_q[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_clken  <= 1'b0;
      post_img    <= '0;
      post_border <= 1'b0;
      frame_done  <= 1'b0;
    end else if (en_fun && s2_valid) begin
      post_clken  <= 1'b1;
      post_img    <= s2_border ? s2_p22 : filt_pix;
      post_border <= s2_border;
      frame_done  <= s2_last;
    end else begin
      // post_img deliberately keeps the last delivered pixel.
      post_clken  <= 1'b0;
      post_border <= 1'b0;
      frame_done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gaussian_conv_3x3.sv
// -----------------------------------------------------------------------------
// tb_gaussian_conv_3x3
// Self-checking bench for gaussian_conv_3x3 on a small 4x3 frame. Accepted
// windows push {pixel, border, done, due cycle} into a scoreboard; a negedge
// monitor pops and compares whenever post_clken is high, and checks that
// post_img holds and side-band flags stay low otherwise.
// -----------------------------------------------------------------------------
module tb_gaussian_conv_3x3;

  localparam int W  = 4;
  localparam int D  = 3;
  localparam int DW = 16;

  typedef logic [8:0][DW-1:0] win_t;  // [0]=p11 ... [4]=p22 ... [8]=p33

  typedef struct {
    string         name;
    win_t          win;
    logic [DW-1:0] exp_img;
  } vec_t;

  typedef struct {
    logic [DW-1:0] img;
    logic          border;
    logic          done;
    int            cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          en_fun;
  logic          matrix_clken;
  logic          data_valid;
  logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;
  logic          post_clken;
  logic [DW-1:0] post_img;
  logic          post_border;
  logic          frame_done;

  gaussian_conv_3x3 #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_fun      (en_fun),
    .matrix_clken(matrix_clken),
    .data_valid  (data_valid),
    .matrix_p11  (matrix_p11),
    .matrix_p12  (matrix_p12),
    .matrix_p13  (matrix_p13),
    .matrix_p21  (matrix_p21),
    .matrix_p22  (matrix_p22),
    .matrix_p23  (matrix_p23),
    .matrix_p31  (matrix_p31),
    .matrix_p32  (matrix_p32),
    .matrix_p33  (matrix_p33),
    .post_clken  (post_clken),
    .post_img    (post_img),
    .post_border (post_border),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_out   = 0;
  int            n_done  = 0;
  logic [DW-1:0] last_img = '0;

  // Reference position model
  int m_col = 0;
  int m_row = 0;
  int m_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic win_t mk(input logic [DW-1:0] a, b, c, d, e, f, g, h, i);
    win_t w;
    w[0] = a; w[1] = b; w[2] = c;
    w[3] = d; w[4] = e; w[5] = f;
    w[6] = g; w[7] = h; w[8] = i;
    return w;
  endfunction

  // Straight weighted sum: taps 1,3,5,7 weigh 2, the centre 4, corners 1.
  function automatic logic [DW-1:0] ref_gauss(input win_t w);
    longint s = 0;
    longint wt;
    for (int k = 0; k < 9; k++) begin
      wt = (k == 4) ? 4 : ((k % 2) == 1) ? 2 : 1;
      s += wt * longint'(w[k]);
    end
    s = (s + 8) / 16;
    if (s > 65535) s = 65535;
    return DW'(s);
  endfunction

  function automatic bit m_border();
    return (m_col == 0) || (m_col == W - 1) || (m_row == 0) || (m_row == D - 1);
  endfunction

  task automatic model_restart();
    m_col = 0;
    m_row = 0;
  endtask

  // Drive one window after the active edge; push the expected result if it
  // will be accepted. has_exp selects the caller-supplied expected pixel.
  task automatic drive(input win_t w, input logic clken, input logic dv,
                       input bit has_exp, input logic [DW-1:0] exp_img);
    exp_t e;
    bit   brd;
    @(posedge clk); #1;
    matrix_p11 = w[0]; matrix_p12 = w[1]; matrix_p13 = w[2];
    matrix_p21 = w[3]; matrix_p22 = w[4]; matrix_p23 = w[5];
    matrix_p31 = w[6]; matrix_p32 = w[7]; matrix_p33 = w[8];
    matrix_clken = clken;
    data_valid   = dv;
    if (clken && !dv && en_fun) begin
      brd      = m_border();
      e.img    = has_exp ? exp_img : (brd ? w[4] : ref_gauss(w));
      e.border = brd;
      e.done   = (m_col == W - 1) && (m_row == D - 1);
      e.cyc    = cyc + 3;
      sb.push_back(e);
      if (e.done) m_frames++;
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == D - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      matrix_clken = 1'b0;
      data_valid   = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      matrix_clken = 1'b0;
      k++;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Output monitor, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      last_img = '0;
    end else if (post_clken) begin
      n_out++;
      if (frame_done) n_done++;
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(post_clken), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_img",    post_img,    mon_e.img);
        check("out_border", post_border, mon_e.border);
        check("out_done",   frame_done,  mon_e.done);
        check("out_cycle",  cyc,         mon_e.cyc);
      end
      last_img = post_img;
    end else begin
      check("hold_img",    post_img,    last_img);
      check("idle_border", post_border, 1'b0);
      check("idle_done",   frame_done,  1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  vec_t          vecs[7];
  win_t          flat;
  win_t          rw;
  int            out0, done0, frames0, acc;
  logic          ck, dv;

  initial begin
    flat = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
              16'h0100, 16'h0100, 16'h0100, 16'h0100);
    vecs[0] = '{"impulse", mk(0, 0, 0, 0, 16'h1000, 0, 0, 0, 0), 16'h0400};
    vecs[1] = '{"all_ones", mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFF};
    vecs[2] = '{"round_up", mk(16'h0008, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0001};
    vecs[3] = '{"round_down", mk(16'h0007, 0, 0, 0, 0, 0, 0, 0, 0), 16'h0000};
    vecs[4] = '{"mixed", mk(10, 20, 30, 40, 50, 60, 70, 80, 90), 16'd50};
    vecs[5] = '{"flat", flat, 16'h0100};
    vecs[6] = '{"edge_tap", mk(0, 0, 0, 16'h0004, 0, 0, 0, 0, 0), 16'h0001};

    rst_n = 1'b0;
    en_fun = 1'b0;
    matrix_clken = 1'b0;
    data_valid = 1'b0;
    {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
     matrix_p23, matrix_p31, matrix_p32, matrix_p33} = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_clken",  post_clken,  1'b0);
    check("rst_img",    post_img,    16'h0000);
    check("rst_border", post_border, 1'b0);
    check("rst_done",   frame_done,  1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    en_fun = 1'b1;

    // Table vectors placed on interior positions, flat fill on the border
    done0 = n_done; frames0 = m_frames;
    for (int v = 0; v < 7; v++) begin
      while (m_border()) drive(flat, 1'b1, 1'b0, 1'b0, '0);
      drive(vecs[v].win, 1'b1, 1'b0, 1'b1, vecs[v].exp_img);
    end
    while (!(m_col == 0 && m_row == 0)) drive(flat, 1'b1, 1'b0, 1'b0, '0);
    wait_drain("drain_table");
    check("table_frames", n_done - done0, m_frames - frames0);

    // Bubbles and row-wrap junk interleaved with accepted windows
    out0 = n_out; acc = 0;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 9; k++) rw[k] = DW'($urandom);
      ck = ($urandom_range(0, 3) != 0);
      dv = ($urandom_range(0, 3) == 0);
      if (ck && !dv) acc++;
      drive(rw, ck, dv, 1'b0, '0);
    end
    idle(1);
    wait_drain("drain_gaps");
    check("gap_out_count", n_out - out0, acc);

    // Complete the current frame, then a full back-to-back frame
    while (!(m_col == 0 && m_row == 0)) drive(flat, 1'b1, 1'b0, 1'b0, '0);
    wait_drain("drain_align");
    out0 = n_out; done0 = n_done;
    for (int i = 0; i < W * D; i++) begin
      for (int k = 0; k < 9; k++) rw[k] = DW'($urandom);
      drive(rw, 1'b1, 1'b0, 1'b0, '0);
    end
    wait_drain("drain_frame");
    check("frame_out_count",  n_out - out0,   W * D);
    check("frame_done_count", n_done - done0, 1);
    drive(flat, 1'b1, 1'b0, 1'b0, '0);  // next frame must start at (0,0)
    wait_drain("drain_restart");

    // en_fun dropped mid-frame: in-flight data is discarded
    for (int i = 0; i < 6; i++) drive(mk(1, 2, 3, 4, 16'h0500, 6, 7, 8, 9), 1'b1, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    en_fun = 1'b0;
    matrix_clken = 1'b0;
    @(posedge clk); #1;
    while (sb.size() != 0 && sb[sb.size() - 1].cyc >= cyc) void'(sb.pop_back());
    model_restart();
    @(negedge clk);
    check("enoff_clken", post_clken, 1'b0);
    check("enoff_done",  frame_done, 1'b0);
    idle(2);
    en_fun = 1'b1;
    for (int i = 0; i < 6; i++) drive(mk(0, 0, 0, 0, 16'h0A00 + DW'(i), 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, '0);
    wait_drain("drain_enoff");

    // rst_n pulsed mid-frame: outputs clear immediately
    for (int i = 0; i < 5; i++) drive(mk(0, 0, 0, 0, 16'h2000, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, '0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    matrix_clken = 1'b0;
    #1;
    check("midrst_clken",  post_clken,  1'b0);
    check("midrst_img",    post_img,    16'h0000);
    check("midrst_border", post_border, 1'b0);
    check("midrst_done",   frame_done,  1'b0);
    sb.delete();
    model_restart();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) drive(mk(0, 0, 0, 0, 16'h0B00 + DW'(i), 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, '0);
    wait_drain("drain_midrst");

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
